// File: rtl/pc_npc_unit_pkg.sv
// Shared CPU definitions for the fetch-PC / next-PC unit: select and branch
// encodings, default vectors and the redirect-buffer state codes.
package pc_npc_unit_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT   = 32'h0000_3000;
  localparam logic [31:0] EXC_VEC_DEFAULT    = 32'h0000_4180;
  localparam logic [31:0] IMEM_BASE_DEFAULT  = 32'h0000_3000;
  localparam logic [31:0] IMEM_BYTES_DEFAULT = 32'h0000_4000;

  typedef enum logic [1:0] {
    NPC_ADD4   = 2'b00,
    NPC_BRANCH = 2'b01,
    NPC_JUMP   = 2'b10,
    NPC_JR     = 2'b11
  } npc_sel_e;

  typedef enum logic [2:0] {
    BR_BEQ  = 3'b000,
    BR_BNE  = 3'b001,
    BR_BLEZ = 3'b010,
    BR_BGTZ = 3'b011,
    BR_BLTZ = 3'b100,
    BR_BGEZ = 3'b101
  } br_op_e;

  // Redirect buffer: IDLE, or HELD while a resolved target waits for imem_ready.
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HELD = 1'b1;

endpackage

// File: rtl/pc_npc_unit_branch_cmp.sv
// Combinational branch-condition evaluator: equality compares of rs/rt and
// signed compares of rs against zero. Reserved opcodes never take.
module branch_cmp
  import pc_npc_unit_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [2:0]        br_op,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rt,
  output logic              cond
);

  logic rs_neg;
  logic rs_zero;

  assign rs_neg  = rs[ADDR_W-1];
  assign rs_zero = (rs == '0);

  // NOTE: every signal written in always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    cond = 1'b0;
    case (br_op)
      BR_BEQ:  cond = (rs == rt);
      BR_BNE:  cond = (rs != rt);
      BR_BLEZ: cond = rs_neg | rs_zero;
      BR_BGTZ: cond = ~rs_neg & ~rs_zero;
      BR_BLTZ: cond = rs_neg;
      BR_BGEZ: cond = ~rs_neg;
      default: cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_npc_unit.sv
// Fetch PC register and next-PC selection with a one-entry redirect buffer
// that holds a resolved branch/jump target while instruction memory is busy.
module pc_npc_unit
  import pc_npc_unit_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(RESET_PC_DEFAULT),
  parameter logic [ADDR_W-1:0] EXC_VEC    = ADDR_W'(EXC_VEC_DEFAULT),
  parameter logic [ADDR_W-1:0] IMEM_BASE  = ADDR_W'(IMEM_BASE_DEFAULT),
  parameter logic [ADDR_W-1:0] IMEM_BYTES = ADDR_W'(IMEM_BYTES_DEFAULT)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              imem_ready,
  input  logic [1:0]        d_npc_sel,
  input  logic [2:0]        d_br_op,
  input  logic [ADDR_W-1:0] d_rs,
  input  logic [ADDR_W-1:0] d_rt,
  input  logic [ADDR_W-1:0] d_pc4,
  input  logic [15:0]       d_imm16,
  input  logic [25:0]       d_imm26,
  input  logic              exc_req,
  input  logic              eret_req,
  input  logic [ADDR_W-1:0] epc,
  output logic [ADDR_W-1:0] f_pc,
  output logic              f_adel,
  output logic              d_taken,
  output logic              redirect_pending
);

  // One extra bit so BASE+BYTES at the top of the address space cannot wrap.
  localparam logic [ADDR_W:0] IMEM_LIMIT = {1'b0, IMEM_BASE} + {1'b0, IMEM_BYTES};

  logic [0:0]        state, state_next;
  logic [ADDR_W-1:0] pend_tgt, pend_next;
  logic [ADDR_W-1:0] f_pc_next;
  logic [ADDR_W-1:0] br_off;
  logic [ADDR_W-1:0] br_tgt;
  logic [ADDR_W-1:0] j_tgt;
  logic [ADDR_W-1:0] d_target;
  logic              br_cond;

  branch_cmp #(
    .ADDR_W (ADDR_W)
  ) u_branch_cmp (
    .br_op (d_br_op),
    .rs    (d_rs),
    .rt    (d_rt),
    .cond  (br_cond)
  );

  assign br_off = {{(ADDR_W-18){d_imm16[15]}}, d_imm16, 2'b00};
  assign br_tgt = d_pc4 + br_off;

  // Upper bits of the jump target come from the delay-slot PC; the low 28
  // bits are replaced, which also covers ADDR_W == 28.
  always_comb begin
    j_tgt       = d_pc4;
    j_tgt[27:0] = {d_imm26, 2'b00};
  end

  always_comb begin
    d_target = br_tgt;
    case (d_npc_sel)
      NPC_JUMP: d_target = j_tgt;
      NPC_JR:   d_target = d_rs;
      default:  d_target = br_tgt;
    endcase
  end

  assign d_taken = (d_npc_sel == NPC_JUMP) || (d_npc_sel == NPC_JR) ||
                   ((d_npc_sel == NPC_BRANCH) && br_cond);

  always_comb begin
    f_pc_next  = f_pc + ADDR_W'(4);
    state_next = state;
    pend_next  = pend_tgt;
    if (exc_req) begin
      f_pc_next  = EXC_VEC;
      state_next = ST_IDLE;
    end else if (eret_req) begin
      f_pc_next  = epc;
      state_next = ST_IDLE;
    end else if ((state == ST_HELD) && imem_ready) begin
      f_pc_next  = pend_tgt;
      state_next = ST_IDLE;
    end else if (stall || !imem_ready) begin
      f_pc_next = f_pc;
      // A stalled D stage recomputes its redirect later, so only an
      // unstalled redirect blocked by memory is captured.
      if ((state == ST_IDLE) && d_taken && !stall) begin
        state_next = ST_HELD;
        pend_next  = d_target;
      end
    end else if (d_taken) begin
      f_pc_next = d_target;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      f_pc     <= RESET_PC;
      state    <= ST_IDLE;
      pend_tgt <= '0;
    end else begin
      f_pc     <= f_pc_next;
      state    <= state_next;
      pend_tgt <= pend_next;
    end
  end

  assign redirect_pending = (state == ST_HELD);

  assign f_adel = (f_pc[1:0] != 2'b00) || (f_pc < IMEM_BASE) ||
                  ({1'b0, f_pc} >= IMEM_LIMIT);

endmodule

// File: tb/tb_pc_npc_unit.sv
// Directed bench for pc_npc_unit: expectations are queued as stimulus is
// driven and popped against the DUT outputs at each sample point.
module tb_pc_npc_unit;
  import pc_npc_unit_pkg::*;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        imem_ready;
  logic [1:0]  d_npc_sel;
  logic [2:0]  d_br_op;
  logic [31:0] d_rs;
  logic [31:0] d_rt;
  logic [31:0] d_pc4;
  logic [15:0] d_imm16;
  logic [25:0] d_imm26;
  logic        exc_req;
  logic        eret_req;
  logic [31:0] epc;
  logic [31:0] f_pc;
  logic        f_adel;
  logic        d_taken;
  logic        redirect_pending;

  pc_npc_unit dut (
    .clk              (clk),
    .reset            (reset),
    .stall            (stall),
    .imem_ready       (imem_ready),
    .d_npc_sel        (d_npc_sel),
    .d_br_op          (d_br_op),
    .d_rs             (d_rs),
    .d_rt             (d_rt),
    .d_pc4            (d_pc4),
    .d_imm16          (d_imm16),
    .d_imm26          (d_imm26),
    .exc_req          (exc_req),
    .eret_req         (eret_req),
    .epc              (epc),
    .f_pc             (f_pc),
    .f_adel           (f_adel),
    .d_taken          (d_taken),
    .redirect_pending (redirect_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum int {K_PC, K_PEND, K_ADEL, K_TAKEN} kind_e;
  typedef struct {
    string       tag;
    kind_e       kind;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic push(input string tag, input kind_e kind, input logic [31:0] v);
    exp_t e;
    e.tag  = tag;
    e.kind = kind;
    e.exp  = v;
    sb.push_back(e);
  endtask

  task automatic check();
    exp_t        e;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.kind)
        K_PC:    obs = f_pc;
        K_PEND:  obs = {31'b0, redirect_pending};
        K_ADEL:  obs = {31'b0, f_adel};
        default: obs = {31'b0, d_taken};
      endcase
      n_cmp++;
      assert (obs === e.exp)
      else begin
        n_bad++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_d(input logic [1:0] sel, input logic [2:0] op,
                       input logic [31:0] rs, input logic [31:0] rt,
                       input logic [31:0] pc4, input logic [15:0] imm16,
                       input logic [25:0] imm26);
    d_npc_sel = sel;
    d_br_op   = op;
    d_rs      = rs;
    d_rt      = rt;
    d_pc4     = pc4;
    d_imm16   = imm16;
    d_imm26   = imm26;
  endtask

  task automatic expect_pc(input string tag, input logic [31:0] pc,
                           input logic pend, input logic adel);
    push({tag, ".pc"},   K_PC,   pc);
    push({tag, ".pend"}, K_PEND, {31'b0, pend});
    push({tag, ".adel"}, K_ADEL, {31'b0, adel});
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        taken;
  } br_vec_t;

  br_vec_t br_tab[9];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    br_tab[0] = '{BR_BGTZ, 32'h0000_0001, 32'h0, 1'b1};
    br_tab[1] = '{BR_BGTZ, 32'h0000_0000, 32'h0, 1'b0};
    br_tab[2] = '{BR_BLTZ, 32'hFFFF_FFFF, 32'h0, 1'b1};
    br_tab[3] = '{BR_BLTZ, 32'h0000_0000, 32'h0, 1'b0};
    br_tab[4] = '{BR_BGEZ, 32'h0000_0000, 32'h0, 1'b1};
    br_tab[5] = '{BR_BGEZ, 32'h8000_0000, 32'h0, 1'b0};
    br_tab[6] = '{BR_BNE,  32'h0000_0001, 32'h2, 1'b1};
    br_tab[7] = '{3'b110,  32'h0000_0000, 32'h0, 1'b0};
    br_tab[8] = '{3'b111,  32'hFFFF_FFFF, 32'h0, 1'b0};

    reset = 1'b1; stall = 1'b0; imem_ready = 1'b1;
    exc_req = 1'b0; eret_req = 1'b0; epc = 32'h0;
    set_d(NPC_ADD4, BR_BEQ, 32'h0, 32'h0, 32'h0, 16'h0, 26'h0);
    step();
    expect_pc("reset", 32'h0000_3000, 1'b0, 1'b0);
    check();

    reset = 1'b0;
    step();
    expect_pc("seq", 32'h0000_3004, 1'b0, 1'b0);
    check();

    set_d(NPC_BRANCH, BR_BEQ, 32'd5, 32'd5, 32'h0000_3004, 16'hFFFF, 26'h0);
    #1; push("beq.taken", K_TAKEN, 32'd1); check();
    step(); expect_pc("beq", 32'h0000_3000, 1'b0, 1'b0); check();

    set_d(NPC_BRANCH, BR_BNE, 32'd5, 32'd5, 32'h0000_3004, 16'hFFFF, 26'h0);
    #1; push("bne_eq.taken", K_TAKEN, 32'd0); check();
    step(); expect_pc("bne_eq", 32'h0000_3004, 1'b0, 1'b0); check();

    set_d(NPC_BRANCH, BR_BLEZ, 32'h8000_0000, 32'h0, 32'h0000_3008, 16'h0010, 26'h0);
    #1; push("blez_neg.taken", K_TAKEN, 32'd1); check();
    step(); expect_pc("blez_neg", 32'h0000_3048, 1'b0, 1'b0); check();

    set_d(NPC_BRANCH, BR_BLEZ, 32'h0000_0001, 32'h0, 32'h0000_304C, 16'h0010, 26'h0);
    #1; push("blez_pos.taken", K_TAKEN, 32'd0); check();
    step(); expect_pc("blez_pos", 32'h0000_304C, 1'b0, 1'b0); check();

    // Condition table under stall: f_pc must hold and nothing is captured.
    stall = 1'b1;
    for (int i = 0; i < 9; i++) begin
      set_d(NPC_BRANCH, br_tab[i].op, br_tab[i].rs, br_tab[i].rt,
            32'h0000_3050, 16'h0040, 26'h0);
      #1; push($sformatf("brtab%0d.taken", i), K_TAKEN, {31'b0, br_tab[i].taken}); check();
      step();
    end
    expect_pc("stall_hold", 32'h0000_304C, 1'b0, 1'b0); check();

    set_d(NPC_JUMP, BR_BEQ, 32'h0, 32'h0, 32'h0000_3050, 16'h0, 26'h000_0C40);
    #1; push("j_stall.taken", K_TAKEN, 32'd1); check();
    step(); expect_pc("j_stall", 32'h0000_304C, 1'b0, 1'b0); check();
    stall = 1'b0;
    step(); expect_pc("j", 32'h0000_3100, 1'b0, 1'b0); check();

    set_d(NPC_ADD4, BR_BEQ, 32'h0, 32'h0, 32'h0, 16'h0, 26'h0);
    step(); expect_pc("seq2", 32'h0000_3104, 1'b0, 1'b0); check();

    set_d(NPC_JR, BR_BEQ, 32'h0000_3100, 32'h0, 32'h0, 16'h0, 26'h0);
    imem_ready = 1'b0;
    step(); expect_pc("jr_held", 32'h0000_3104, 1'b1, 1'b0); check();
    set_d(NPC_ADD4, BR_BEQ, 32'h0, 32'h0, 32'h0, 16'h0, 26'h0);
    step(); expect_pc("jr_held2", 32'h0000_3104, 1'b1, 1'b0); check();
    imem_ready = 1'b1;
    step(); expect_pc("jr_apply", 32'h0000_3100, 1'b0, 1'b0); check();

    set_d(NPC_JR, BR_BEQ, 32'h0000_3200, 32'h0, 32'h0, 16'h0, 26'h0);
    imem_ready = 1'b0;
    step(); expect_pc("held_again", 32'h0000_3100, 1'b1, 1'b0); check();
    set_d(NPC_ADD4, BR_BEQ, 32'h0, 32'h0, 32'h0, 16'h0, 26'h0);
    exc_req = 1'b1; eret_req = 1'b1; epc = 32'h0000_3008;
    step(); expect_pc("exc", 32'h0000_4180, 1'b0, 1'b0); check();
    exc_req = 1'b0;
    step(); expect_pc("eret", 32'h0000_3008, 1'b0, 1'b0); check();
    eret_req = 1'b0; imem_ready = 1'b1;

    set_d(NPC_JR, BR_BEQ, 32'h0000_3002, 32'h0, 32'h0, 16'h0, 26'h0);
    step(); expect_pc("adel_align", 32'h0000_3002, 1'b0, 1'b1); check();
    set_d(NPC_JR, BR_BEQ, 32'h0000_7000, 32'h0, 32'h0, 16'h0, 26'h0);
    step(); expect_pc("adel_high", 32'h0000_7000, 1'b0, 1'b1); check();
    set_d(NPC_JR, BR_BEQ, 32'h0000_6FFC, 32'h0, 32'h0, 16'h0, 26'h0);
    step(); expect_pc("adel_top_ok", 32'h0000_6FFC, 1'b0, 1'b0); check();
    set_d(NPC_JR, BR_BEQ, 32'h0000_2FFC, 32'h0, 32'h0, 16'h0, 26'h0);
    step(); expect_pc("adel_low", 32'h0000_2FFC, 1'b0, 1'b1); check();
    set_d(NPC_ADD4, BR_BEQ, 32'h0, 32'h0, 32'h0, 16'h0, 26'h0);
    step(); expect_pc("adel_advance", 32'h0000_3000, 1'b0, 1'b0); check();
    step(); expect_pc("seq3", 32'h0000_3004, 1'b0, 1'b0); check();

    // Reset while HELD beats exception and drops the buffered target.
    set_d(NPC_JR, BR_BEQ, 32'h0000_3200, 32'h0, 32'h0, 16'h0, 26'h0);
    imem_ready = 1'b0;
    step(); expect_pc("held_pre_rst", 32'h0000_3004, 1'b1, 1'b0); check();
    reset = 1'b1; exc_req = 1'b1; imem_ready = 1'b1;
    set_d(NPC_ADD4, BR_BEQ, 32'h0, 32'h0, 32'h0, 16'h0, 26'h0);
    step(); expect_pc("rst_held", 32'h0000_3000, 1'b0, 1'b0); check();
    reset = 1'b0; exc_req = 1'b0;
    step(); expect_pc("post_rst", 32'h0000_3004, 1'b0, 1'b0); check();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
